// File: rtl/exec_resolve_pkg.sv
// Shared opsel encodings and instruction classification for the ALU and the resolve stage.
package exec_resolve_pkg;

  localparam logic [5:0] OP_BF   = 6'd0;
  localparam logic [5:0] OP_BEQ  = 6'd1;
  localparam logic [5:0] OP_BLT  = 6'd2;
  localparam logic [5:0] OP_BLE  = 6'd3;
  localparam logic [5:0] OP_BEQZ = 6'd5;
  localparam logic [5:0] OP_BLTZ = 6'd6;
  localparam logic [5:0] OP_BLEZ = 6'd7;
  localparam logic [5:0] OP_BT   = 6'd8;
  localparam logic [5:0] OP_BNE  = 6'd9;
  localparam logic [5:0] OP_BGE  = 6'd10;
  localparam logic [5:0] OP_BGT  = 6'd11;
  localparam logic [5:0] OP_BNEZ = 6'd13;
  localparam logic [5:0] OP_BGEZ = 6'd14;
  localparam logic [5:0] OP_BGTZ = 6'd15;
  localparam logic [5:0] OP_ADD  = 6'd16;
  localparam logic [5:0] OP_SUB  = 6'd17;
  localparam logic [5:0] OP_AND  = 6'd20;
  localparam logic [5:0] OP_OR   = 6'd21;
  localparam logic [5:0] OP_XOR  = 6'd22;
  localparam logic [5:0] OP_MVHI = 6'd27;
  localparam logic [5:0] OP_NAND = 6'd28;
  localparam logic [5:0] OP_NOR  = 6'd29;
  localparam logic [5:0] OP_XNOR = 6'd30;
  localparam logic [5:0] OP_JALR = 6'd32;

  typedef enum logic [2:0] {
    CLS_BRANCH,
    CLS_JALR,
    CLS_ALU,
    CLS_MVHI,
    CLS_ILLEGAL
  } op_class_e;

  typedef enum logic {
    SQ_IDLE,
    SQ_SQUASH
  } sq_state_e;

  function automatic op_class_e classify(input logic [5:0] opsel);
    op_class_e cls;
    case (opsel)
      OP_BF, OP_BEQ, OP_BLT, OP_BLE, OP_BEQZ, OP_BLTZ, OP_BLEZ,
      OP_BT, OP_BNE, OP_BGE, OP_BGT, OP_BNEZ, OP_BGEZ, OP_BGTZ: cls = CLS_BRANCH;
      OP_JALR:                                                  cls = CLS_JALR;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_NAND, OP_NOR, OP_XNOR:                                 cls = CLS_ALU;
      OP_MVHI:                                                  cls = CLS_MVHI;
      default:                                                  cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/exec_squash_ctr.sv
// Wrong-path squash window: counts down FLUSH_DEPTH cycles after a redirect.
// Registered squashing flag; flush clears the window at the next edge; no backpressure.
module exec_squash_ctr
  import exec_resolve_pkg::*;
#(
  parameter int FLUSH_DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic flush,
  input  logic tick,
  output logic squashing
);

  sq_state_e  state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SQ_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = SQ_IDLE;
      cnt_d   = 3'd0;
    end else begin
      case (state_q)
        SQ_IDLE: begin
          if (load) begin
            state_d = SQ_SQUASH;
            cnt_d   = 3'(FLUSH_DEPTH);
          end
        end
        SQ_SQUASH: begin
          if (tick) begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) state_d = SQ_IDLE;
          end
        end
        default: begin
          state_d = SQ_IDLE;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  assign squashing = (cnt_q != 3'd0);

endmodule

// File: rtl/exec_resolve.sv
// Resolves branches/JALR and builds writeback from the registered ALU result.
// Latency 2 cycles from in_valid; 1 instruction/cycle, no backpressure.
module exec_resolve
  import exec_resolve_pkg::*;
#(
  parameter int FLUSH_DEPTH = 2,
  parameter int PC_W        = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [5:0]      in_opsel,
  input  logic [PC_W-1:0] in_pc,
  input  logic [15:0]     in_imm,
  input  logic [3:0]      in_rd,
  input  logic [15:0]     in_rd_lo,
  input  logic [PC_W-1:0] alu_out,
  input  logic            flush,
  output logic            wb_valid,
  output logic [3:0]      wb_rd,
  output logic [PC_W-1:0] wb_data,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic            illegal,
  output logic            squashing,
  output logic [31:0]     retire_count
);

  logic            s1_valid_q, s1_valid_d;
  logic [5:0]      s1_opsel_q;
  logic [PC_W-1:0] s1_pc_q;
  logic [15:0]     s1_imm_q;
  logic [3:0]      s1_rd_q;
  logic [15:0]     s1_rd_lo_q;

  logic            wb_valid_q, wb_valid_d;
  logic [3:0]      wb_rd_q, wb_rd_d;
  logic [PC_W-1:0] wb_data_q, wb_data_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;
  logic            illegal_q, illegal_d;
  logic [31:0]     retire_q, retire_d;

  logic            squash_active;
  logic            live;
  op_class_e       cls;
  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] br_target;

  // An instruction issued in a flush cycle is already wrong-path.
  assign s1_valid_d = in_valid & ~flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q       <= 1'b0;
      s1_opsel_q       <= '0;
      s1_pc_q          <= '0;
      s1_imm_q         <= '0;
      s1_rd_q          <= '0;
      s1_rd_lo_q       <= '0;
      wb_valid_q       <= 1'b0;
      wb_rd_q          <= '0;
      wb_data_q        <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      illegal_q        <= 1'b0;
      retire_q         <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (in_valid) begin
        s1_opsel_q <= in_opsel;
        s1_pc_q    <= in_pc;
        s1_imm_q   <= in_imm;
        s1_rd_q    <= in_rd;
        s1_rd_lo_q <= in_rd_lo;
      end
      wb_valid_q       <= wb_valid_d;
      wb_rd_q          <= wb_rd_d;
      wb_data_q        <= wb_data_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      illegal_q        <= illegal_d;
      retire_q         <= retire_d;
    end
  end

  always_comb begin
    cls       = classify(s1_opsel_q);
    live      = s1_valid_q & ~flush & ~squash_active;
    pc_plus4  = s1_pc_q + PC_W'(4);
    br_target = pc_plus4 + {{(PC_W-18){s1_imm_q[15]}}, s1_imm_q, 2'b00};

    wb_valid_d       = 1'b0;
    wb_rd_d          = wb_rd_q;
    wb_data_d        = wb_data_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    illegal_d        = 1'b0;
    retire_d         = retire_q;

    if (live) begin
      case (cls)
        CLS_BRANCH: begin
          retire_d = retire_q + 32'd1;
          if (alu_out[0]) begin
            redirect_valid_d = 1'b1;
            redirect_pc_d    = br_target;
          end
        end
        CLS_JALR: begin
          retire_d         = retire_q + 32'd1;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = alu_out;
          wb_valid_d       = 1'b1;
          wb_rd_d          = s1_rd_q;
          wb_data_d        = pc_plus4;
        end
        CLS_ALU: begin
          retire_d   = retire_q + 32'd1;
          wb_valid_d = 1'b1;
          wb_rd_d    = s1_rd_q;
          wb_data_d  = alu_out;
        end
        CLS_MVHI: begin
          retire_d   = retire_q + 32'd1;
          wb_valid_d = 1'b1;
          wb_rd_d    = s1_rd_q;
          wb_data_d  = {alu_out[PC_W-1:16], s1_rd_lo_q};
        end
        default: illegal_d = 1'b1;
      endcase
    end
  end

  exec_squash_ctr #(
    .FLUSH_DEPTH(FLUSH_DEPTH)
  ) u_squash (
    .clk      (clk),
    .reset    (reset),
    .load     (redirect_valid_d),
    .flush    (flush),
    .tick     (1'b1),
    .squashing(squash_active)
  );

  assign wb_valid       = wb_valid_q;
  assign wb_rd          = wb_rd_q;
  assign wb_data        = wb_data_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign illegal        = illegal_q;
  assign squashing      = squash_active;
  assign retire_count   = retire_q;

endmodule

// File: tb/tb_exec_resolve.sv
// Randomized + directed bench for exec_resolve with a queue-based scoreboard.
module tb_exec_resolve;

  localparam int D = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [5:0]  in_opsel;
  logic [31:0] in_pc;
  logic [15:0] in_imm;
  logic [3:0]  in_rd;
  logic [15:0] in_rd_lo;
  logic [31:0] alu_out;
  logic        flush;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        illegal;
  logic        squashing;
  logic [31:0] retire_count;

  exec_resolve #(.FLUSH_DEPTH(D), .PC_W(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_opsel(in_opsel),
    .in_pc(in_pc), .in_imm(in_imm), .in_rd(in_rd), .in_rd_lo(in_rd_lo),
    .alu_out(alu_out), .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .illegal(illegal), .squashing(squashing), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        wv;
    logic [3:0]  rd;
    logic [31:0] wd;
    logic        rv;
    logic [31:0] rpc;
    logic        ill;
    logic [31:0] ret;
  } exp_t;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] pc;
    logic [15:0] imm;
    logic [3:0]  rd;
    logic [15:0] rdlo;
    logic [31:0] alu;
  } ins_t;

  exp_t        q[$];
  bit          exp_sq[int];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          squash_until = -1;
  logic [31:0] model_ret = 32'd0;
  bit          pend_v = 1'b0;
  ins_t        pend;

  logic [5:0] br_ops [14] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd5, 6'd6, 6'd7,
                              6'd8, 6'd9, 6'd10, 6'd11, 6'd13, 6'd14, 6'd15};
  logic [5:0] alu_ops [8] = '{6'd16, 6'd17, 6'd20, 6'd21, 6'd22, 6'd28, 6'd29, 6'd30};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // 0 branch, 1 jalr, 2 alu, 3 mvhi, 4 illegal
  function automatic int op_kind(input logic [5:0] op);
    if (op == 6'd32) return 1;
    if (op < 6'd16 && op != 6'd4 && op != 6'd12) return 0;
    if (op inside {6'd16, 6'd17, 6'd20, 6'd21, 6'd22, 6'd28, 6'd29, 6'd30}) return 2;
    if (op == 6'd27) return 3;
    return 4;
  endfunction

  // Instruction held from last cycle resolves now; its effect shows next cycle.
  task automatic model_resolve(input logic fl);
    exp_t e;
    int   k;
    int   off;
    bit   redir;
    redir = 1'b0;
    if (pend_v && !fl && cyc > squash_until) begin
      k     = op_kind(pend.op);
      e.cyc = cyc + 1;
      e.wv  = 1'b0; e.rd = 4'h0; e.wd = 32'h0;
      e.rv  = 1'b0; e.rpc = 32'h0; e.ill = 1'b0;
      off   = $signed(pend.imm);
      off   = off * 4;
      case (k)
        0: if (pend.alu[0]) begin e.rv = 1'b1; e.rpc = pend.pc + 32'd4 + 32'(off); end
        1: begin
          e.rv = 1'b1; e.rpc = pend.alu;
          e.wv = 1'b1; e.rd = pend.rd; e.wd = pend.pc + 32'd4;
        end
        2: begin e.wv = 1'b1; e.rd = pend.rd; e.wd = pend.alu; end
        3: begin e.wv = 1'b1; e.rd = pend.rd; e.wd = {pend.alu[31:16], pend.rdlo}; end
        default: e.ill = 1'b1;
      endcase
      if (k != 4) model_ret = model_ret + 32'd1;
      e.ret = model_ret;
      if (e.wv || e.rv || e.ill) q.push_back(e);
      redir = e.rv;
    end
    if (fl) squash_until = cyc;
    else if (redir) squash_until = cyc + D;
    exp_sq[cyc+1] = (cyc + 1 <= squash_until);
  endtask

  task automatic step(input logic v, input logic [5:0] op, input logic [31:0] pc,
                      input logic [15:0] imm, input logic [3:0] rd, input logic [15:0] rdlo,
                      input logic [31:0] alu, input logic fl);
    @(posedge clk);
    cyc++;
    #1;
    alu_out  = pend_v ? pend.alu : $urandom;
    flush    = fl;
    in_valid = v;
    in_opsel = op;
    in_pc    = pc;
    in_imm   = imm;
    in_rd    = rd;
    in_rd_lo = rdlo;
    model_resolve(fl);
    pend_v    = v && !fl;
    pend.op   = op;
    pend.pc   = pc;
    pend.imm  = imm;
    pend.rd   = rd;
    pend.rdlo = rdlo;
    pend.alu  = alu;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 6'd0, $urandom, 16'h0, 4'h0, 16'h0, 32'h0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
    chk({tag, "_wb_rd"}, 32'(wb_rd), 32'd0);
    chk({tag, "_wb_data"}, wb_data, 32'd0);
    chk({tag, "_redirect_valid"}, 32'(redirect_valid), 32'd0);
    chk({tag, "_redirect_pc"}, redirect_pc, 32'd0);
    chk({tag, "_illegal"}, 32'(illegal), 32'd0);
    chk({tag, "_squashing"}, 32'(squashing), 32'd0);
    chk({tag, "_retire_count"}, retire_count, 32'd0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
          e = q.pop_front();
          checks++;
          errors++;
          $display("FAIL missing_output cyc=%0d expected_at=%0d wv=%b rv=%b ill=%b",
                   cyc, e.cyc, e.wv, e.rv, e.ill);
        end
        if (wb_valid || redirect_valid || illegal) begin
          if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            chk("wb_valid", 32'(wb_valid), 32'(e.wv));
            if (e.wv) begin
              chk("wb_rd", 32'(wb_rd), 32'(e.rd));
              chk("wb_data", wb_data, e.wd);
            end
            chk("redirect_valid", 32'(redirect_valid), 32'(e.rv));
            if (e.rv) chk("redirect_pc", redirect_pc, e.rpc);
            chk("illegal", 32'(illegal), 32'(e.ill));
            chk("retire_count", retire_count, e.ret);
          end else begin
            checks++;
            errors++;
            $display("FAIL spurious_output cyc=%0d actual wv=%b rv=%b ill=%b required none",
                     cyc, wb_valid, redirect_valid, illegal);
          end
        end
        if (exp_sq.exists(cyc)) chk("squashing", 32'(squashing), 32'(exp_sq[cyc]));
      end
    end
  end

  logic        r_v;
  logic        r_fl;
  logic [5:0]  r_op;
  int          r_sel;

  initial begin
    in_valid = 1'b0; in_opsel = '0; in_pc = '0; in_imm = '0; in_rd = '0;
    in_rd_lo = '0; alu_out = '0; flush = 1'b0;
    reset = 1'b1;
    #1;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b0;

    // ADD pc=0x100 rd=3 alu=7
    step(1'b1, 6'd16, 32'h100, 16'h0, 4'd3, 16'h0, 32'h7, 1'b0);
    idle(3);
    // taken BEQ then two wrong-path ADDs
    step(1'b1, 6'd1, 32'h200, 16'hFFFE, 4'd0, 16'h0, 32'h1, 1'b0);
    step(1'b1, 6'd16, 32'h204, 16'h0, 4'd1, 16'h0, 32'h11, 1'b0);
    step(1'b1, 6'd16, 32'h208, 16'h0, 4'd2, 16'h0, 32'h22, 1'b0);
    idle(4);
    // JALR
    step(1'b1, 6'd32, 32'h40, 16'h0, 4'd15, 16'h0, 32'h1000, 1'b0);
    idle(4);
    // MVHI then opsel 4 (illegal)
    step(1'b1, 6'd27, 32'h80, 16'h0, 4'd7, 16'hBEEF, 32'h1234_5678, 1'b0);
    step(1'b1, 6'd4, 32'h84, 16'h0, 4'd8, 16'h0, 32'h9, 1'b0);
    idle(2);
    // taken BNE resolving under flush, then SUB
    step(1'b1, 6'd9, 32'h300, 16'h0010, 4'd0, 16'h0, 32'h1, 1'b0);
    step(1'b0, 6'd0, 32'h0, 16'h0, 4'd0, 16'h0, 32'h0, 1'b1);
    step(1'b1, 6'd17, 32'h400, 16'h0, 4'd5, 16'h0, 32'h5, 1'b0);
    idle(4);

    for (int i = 0; i < 600; i++) begin
      r_sel = $urandom_range(0, 11);
      r_v   = 1'b1;
      case (r_sel)
        0, 1, 2, 3: r_op = br_ops[$urandom_range(0, 13)];
        4:          r_op = 6'd32;
        5, 6, 7:    r_op = alu_ops[$urandom_range(0, 7)];
        8:          r_op = 6'd27;
        9:          r_op = 6'($urandom_range(0, 63));
        default: begin r_op = 6'd0; r_v = 1'b0; end
      endcase
      r_fl = ($urandom_range(0, 19) == 0);
      step(r_v, r_op, $urandom & 32'hFFFF_FFFC, 16'($urandom), 4'($urandom),
           16'($urandom), $urandom, r_fl);
    end
    idle(4);

    // reset asserted between edges while a squash window is open
    step(1'b1, 6'd2, 32'h500, 16'h0004, 4'd0, 16'h0, 32'h1, 1'b0);
    idle(2);
    chk("pre_reset_squashing", 32'(squashing), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    q.delete();
    exp_sq.delete();
    model_ret    = 32'd0;
    pend_v       = 1'b0;
    squash_until = -1;
    in_valid     = 1'b0;
    flush        = 1'b0;
    @(negedge clk);
    #1 reset = 1'b0;
    step(1'b1, 6'd16, 32'h600, 16'h0, 4'd9, 16'h0, 32'hCAFE, 1'b0);
    idle(5);

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exec_resolve.md
Name: exec_resolve

Overview:
- Stage directly downstream of the registered ALU; consumes its `out` one cycle after issue.
- Aligns per-instruction metadata with the ALU result.
- Resolves branches and JALR into a PC redirect and produces the register-writeback request.
- Squashes wrong-path instructions already in flight after a taken redirect.

Parameters:
FLUSH_DEPTH, 2, cycles of younger instructions squashed after a redirect (1..7)
PC_W, 32, width of PC and data paths

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  instruction issued this cycle (same cycle its opsel/A/B reach the ALU)
in_opsel  in  6  ALU opsel of the issued instruction
in_pc  in  32  PC of issued instruction
in_imm  in  16  branch offset in words, signed
in_rd  in  4  destination register
in_rd_lo  in  16  current rd[15:0], used for MVHI merge
alu_out  in  32  ALU result; valid the cycle after issue
flush  in  1  external pipeline flush
wb_valid  out  1  writeback request
wb_rd  out  4  writeback register
wb_data  out  32  writeback value
redirect_valid  out  1  one-cycle pulse: fetch must jump
redirect_pc  out  32  redirect target
illegal  out  1  one-cycle pulse: unsupported opsel reached resolve
squashing  out  1  squash counter nonzero
retire_count  out  32  count of non-squashed legal instructions resolved; wraps

Behaviour:
- Reset (async, reset=1): every output is 0, s1_valid=0, squash counter=0.
- Pipeline timing: issue in cycle t → metadata captured in s1 at end of t → alu_out sampled with s1 during t+1 → outputs registered at end of t+1 → visible in cycle t+2. Latency is 2 cycles from in_valid.
- Outputs are registered. wb_valid, redirect_valid and illegal are each 1-cycle pulses per resolved instruction.
- Opsel classes:
  - Branch (0-3, 5-11, 13-15): taken iff alu_out[0]=1. Target = in_pc + 4 + (sign_ext(imm) << 2), mod 2^32. No writeback.
  - JALR (32): always redirects; redirect_pc = alu_out. wb_valid=1, wb_data = pc + 4.
  - ALU ops (16, 17, 20-22, 28-30): wb_data = alu_out.
  - MVHI (27): wb_data = {alu_out[31:16], rd_lo}.
  - Any other opsel: no wb, no redirect; illegal=1; not counted in retire_count.
- Squash FSM, states IDLE / SQUASH:
  - IDLE → SQUASH when a redirect is registered; counter loads FLUSH_DEPTH.
  - In SQUASH, each cycle decrements the counter. Any valid s1 entry resolved that cycle produces no wb, no redirect, no illegal, and no count.
  - Counter 0 → IDLE.
  - squashing = (counter != 0).
  - Squashing is by cycles, not by instruction count: bubbles consume squash cycles.
- flush=1: s1_valid cleared at the next edge and counter forced to 0. The entry resolving in that same cycle is suppressed. flush overrides a simultaneous redirect: no redirect is issued.
- Simultaneous in_valid and resolve: allowed every cycle; throughput is 1 instruction per cycle, with no backpressure.
- Reset mid-squash or mid-flight drops all state immediately; retire_count returns to 0.
- retire_count increments by 1 per wb-or-non-taken/taken branch resolution of a legal instruction; it wraps from 0xFFFFFFFF to 0.

Decomposition:
- Shared package holds:
  - opsel constants: BF…BGTZ, ADD, SUB, AND, OR, XOR, MVHI, NAND, NOR, XNOR, JALR.
  - opsel-class enum: BRANCH, JALR, ALU, MVHI, ILLEGAL.
  - function classify(opsel) → class.
  - The ALU module also uses this package.
- Sub-module: exec_squash_ctr, holding the counter and IDLE/SQUASH FSM, with inputs load, flush and tick.

Test Plan:
- ADD issued at t, pc=0x100, rd=3; alu_out=0x0000_0007 at t+1 → cycle t+2: wb_valid=1, wb_rd=3, wb_data=7, redirect_valid=0, retire_count=1.
- BEQ, pc=0x200, imm=0xFFFE, alu_out=1, followed by two issued ADDs → redirect_pc=0x1FC at t+2. Both ADDs suppressed (no wb_valid). squashing high 2 cycles. retire_count=1.
- JALR, pc=0x40, rd=15, alu_out=0x0000_1000 → redirect_pc=0x1000, wb_rd=15, wb_data=0x44.
- MVHI, rd_lo=0xBEEF, alu_out=0x1234_xxxx → wb_data=0x1234_BEEF. Opsel 4 → illegal pulse only, count unchanged.
- Taken BNE resolving in same cycle as flush=1 → no redirect, squashing=0. Next instruction (SUB, alu_out=5) resolves normally.
- Assert reset asynchronously mid-SQUASH, between edges → all outputs 0 immediately. After release, an ADD resolves normally with retire_count=1.
